// File: rtl/mac_seq_acc.sv
// Multi-cycle shift-add multiply-accumulate engine with valid/ready operand handshake,
// per-op signed/unsigned and load/accumulate modes, and a saturating or wrapping accumulator.
module mac_seq_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  input  logic              in_load,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  acc_out,
  output logic              done,
  output logic              ovf,
  output logic              busy
);

  localparam int P_W   = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;

  logic [P_W-1:0]        mcand_p0;
  logic [DATA_W-1:0]     mplier_p0;
  logic [P_W-1:0]        prod_p0;
  logic                  neg_p0;
  logic                  sgn_p0;
  logic                  load_p0;

  logic signed [ACC_W-1:0] prod_s;
  logic [ACC_W:0]          acc_add;

  // Magnitude of a possibly negative operand; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
    logic [DATA_W-1:0] r;
    r = (s && v[DATA_W-1]) ? (~v + 1'b1) : v;
    return r;
  endfunction

  // Returns {overflow, result}; clamps to the representable limit when SAT is set.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] p,
                                             input logic s);
    logic [ACC_W:0]   u;
    logic [ACC_W-1:0] r;
    logic             o;
    u = {1'b0, a} + {1'b0, p};
    r = u[ACC_W-1:0];
    if (s) o = (a[ACC_W-1] == p[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
    else   o = u[ACC_W];
    if (o && (SAT != 0)) begin
      if (!s)                r = '1;
      else if (a[ACC_W-1])   r = {1'b1, {(ACC_W-1){1'b0}}};
      else                   r = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return {o, r};
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (cnt == CNT_W'(DATA_W - 1)) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= '0;
      else if (state == MUL)   cnt <= cnt + 1'b1;
    end
  end

  // Stage 0: operand capture and one partial product per clock
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0  <= P_W'(mag(in_a, in_signed));
      mplier_p0 <= mag(in_b, in_signed);
      prod_p0   <= '0;
      neg_p0    <= in_signed & (in_a[DATA_W-1] ^ in_b[DATA_W-1]);
      sgn_p0    <= in_signed;
      load_p0   <= in_load;
    end else if (state == MUL) begin
      if (mplier_p0[0]) prod_p0 <= prod_p0 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  always_comb begin
    prod_s  = neg_p0 ? $signed(~ACC_W'(prod_p0) + 1'b1) : $signed(ACC_W'(prod_p0));
    acc_add = sat_add(acc_out, prod_s, sgn_p0);
  end

  // Stage 1: accumulator update; a coincident clear overrides the result but not done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == ACC);
      if (acc_clr) begin
        acc_out <= '0;
        ovf     <= 1'b0;
      end else if (state == ACC) begin
        if (load_p0) begin
          acc_out <= prod_s;
        end else begin
          acc_out <= acc_add[ACC_W-1:0];
          if (acc_add[ACC_W]) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_acc.sv
// Scoreboard bench for mac_seq_acc: driver pushes expected results, a monitor checks each done pulse.
module tb_mac_seq_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_signed, in_load, acc_clr;
  logic [7:0]  in_a, in_b;
  logic        in_ready, done, ovf, busy;
  logic [23:0] acc_out;
  logic        in_ready1, done1, ovf1, busy1;
  logic [23:0] acc_out1;

  always #5 clk = ~clk;

  mac_seq_acc #(.DATA_W(8), .ACC_W(24), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_load(in_load),
    .acc_clr(acc_clr), .acc_out(acc_out), .done(done), .ovf(ovf), .busy(busy)
  );

  // Wrapping variant shares all stimulus; only checked where overflow occurs.
  mac_seq_acc #(.DATA_W(8), .ACC_W(24), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_load(in_load),
    .acc_clr(acc_clr), .acc_out(acc_out1), .done(done1), .ovf(ovf1), .busy(busy1)
  );

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done pulsed with acc_out=0x%0h, none expected (t=%0t)",
                 acc_out, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("acc_out", acc_out, mon_e.acc);
        chk("ovf", ovf, mon_e.ovf);
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic l,
                       input int clr_at, input logic hold,
                       input logic [23:0] ea, input logic eo);
    int n;
    n = 0;
    while (in_ready !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
        return;
      end
    end
    sb.push_back('{acc: ea, ovf: eo});
    in_a = a; in_b = b; in_signed = s; in_load = l; in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    chk("ready_after_accept", in_ready, 0);
    n = 0;
    do begin
      n++;
      if (n == clr_at) acc_clr = 1'b1;
      @(posedge clk); #1;
      if (n == clr_at) begin
        acc_clr = 1'b0;
        if (n <= 8) begin
          chk("clr_acc", acc_out, 0);
          chk("clr_ovf", ovf, 0);
        end
      end
      if (done !== 1'b1) begin
        chk("ready_busy", in_ready, 0);
        chk("busy", busy, 1);
      end
    end while (done !== 1'b1 && n < 50);
    in_valid = 1'b0;
    chk("latency", n, 9);
    chk("ready_with_done", in_ready, 1);
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("clear_acc", acc_out, 0);
    chk("clear_ovf", ovf, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_load = 1'b0; acc_clr = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned 200*150 from reset
    do_op(8'd200, 8'd150, 1'b0, 1'b0, 0, 1'b0, 24'h007530, 1'b0);

    // Signed -3*5 then -128*-128
    clear_acc();
    do_op(8'hFD, 8'h05, 1'b1, 1'b0, 0, 1'b0, 24'hFFFFF1, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 0, 1'b0, 24'h003FF1, 1'b0);

    // Load with in_valid held high through busy
    do_op(8'd2, 8'd3, 1'b0, 1'b1, 0, 1'b1, 24'h000006, 1'b0);
    @(posedge clk); #1;
    chk("single_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("single_accept_ready2", in_ready, 1);

    // acc_clr during MUL, then on the ACC cycle
    do_op(8'd20, 8'd25, 1'b0, 1'b1, 0, 1'b0, 24'd500, 1'b0);
    do_op(8'd10, 8'd10, 1'b0, 1'b0, 3, 1'b0, 24'd100, 1'b0);
    do_op(8'd5,  8'd5,  1'b0, 1'b0, 9, 1'b0, 24'd0,   1'b0);

    // Signed positive saturation after 512 ops of 2^14
    clear_acc();
    for (int i = 0; i < 512; i++) begin
      if (i < 511) do_op(8'h80, 8'h80, 1'b1, 1'b0, 0, 1'b0, 24'((i + 1) * 16384), 1'b0);
      else         do_op(8'h80, 8'h80, 1'b1, 1'b0, 0, 1'b0, 24'h7FFFFF, 1'b1);
    end
    chk("wrap_signed_acc", acc_out1, 32'h800000);
    chk("wrap_signed_ovf", ovf1, 1);

    // Unsigned carry-out: 0xFFFFFF + 1
    clear_acc();
    do_op(8'hFF, 8'h01, 1'b1, 1'b1, 0, 1'b0, 24'hFFFFFF, 1'b0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 24'hFFFFFF, 1'b1);
    chk("wrap_unsigned_acc", acc_out1, 32'h000000);
    chk("wrap_unsigned_ovf", ovf1, 1);

    // Reset mid-MUL aborts the op
    in_a = 8'd10; in_b = 8'd10; in_signed = 1'b0; in_load = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc_out, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_ready", in_ready, 1);
    chk("postrst_acc", acc_out, 0);
    do_op(8'd7, 8'd7, 1'b0, 1'b0, 0, 1'b0, 24'd49, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
